// File: rtl/sccpu_run_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// Package: sccpu_dbg_defs
// Shared debug definitions for the single-cycle MIPS run controller:
//   - run_state_t  : sequencer state encoding (IDLE=0, RUN=1, STEP=2, HALT=3)
//   - stop_cause_t : reason the core last stopped
//   - BREAK opcode/funct constants and a decode helper
// ----------------------------------------------------------------------------
package sccpu_dbg_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_HOST  = 2'd0,
    CAUSE_BREAK = 2'd1,
    CAUSE_BKPT  = 2'd2,
    CAUSE_LIMIT = 2'd3
  } stop_cause_t;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] FUNCT_BREAK = 6'h0D;

  // BREAK is an R-type (SPECIAL) instruction; the code field in bits 25:6
  // carries no meaning for the sequencer.
  function automatic logic is_break(input logic [31:0] insn);
    return (insn[31:26] == OP_SPECIAL) && (insn[5:0] == FUNCT_BREAK);
  endfunction

endpackage

// File: rtl/sccpu_run_ctrl_stopdet.sv
// ----------------------------------------------------------------------------
// Module: run_ctrl_stopdet
// Combinational stop-condition detector for the run controller.
// Build option: RUN_CTRL_BKPT_EN enables the PC breakpoint comparator.
// Ports:
//   halt_req   in  1      host halt request
//   skip       in  1      first cycle after a resume: mask BREAK/breakpoint
//   instr      in  32     instruction at the current PC
//   pc         in  32     current PC
//   bkpt_addr  in  32     breakpoint PC
//   bkpt_valid in  1      breakpoint armed
//   instr_cnt  in  CNT_W  retired-instruction count
//   stop       out 1      any stop condition present this cycle
//   cause      out 2      highest-priority stop reason
// ----------------------------------------------------------------------------
module run_ctrl_stopdet
  import sccpu_dbg_defs::*;
#(
  parameter int unsigned       CNT_W     = 32,
  parameter logic [CNT_W-1:0]  MAX_INSTR = '0
) (
  input  logic              halt_req,
  input  logic              skip,
  input  logic [31:0]       instr,
  input  logic [31:0]       pc,
  input  logic [31:0]       bkpt_addr,
  input  logic              bkpt_valid,
  input  logic [CNT_W-1:0]  instr_cnt,
  output logic              stop,
  output stop_cause_t       cause
);

  logic brk;
  logic lim;
  logic bkp;

  // The skip flag lets a resume commit the BREAK/breakpoint it stopped on;
  // it deliberately does not mask the host halt or the instruction limit.
  assign brk = !skip && is_break(instr);
  assign lim = (MAX_INSTR != '0) && (instr_cnt == MAX_INSTR);

`ifdef RUN_CTRL_BKPT_EN
  assign bkp = !skip && bkpt_valid && (pc == bkpt_addr);
`else
  logic unused_bkpt;
  assign bkp         = 1'b0;
  assign unused_bkpt = ^{pc, bkpt_addr, bkpt_valid};
`endif

  // Cause priority: host halt > BREAK > breakpoint > limit.
  always_comb begin
    stop  = halt_req || brk || bkp || lim;
    cause = CAUSE_HOST;
    if (halt_req)  cause = CAUSE_HOST;
    else if (brk)  cause = CAUSE_BREAK;
    else if (bkp)  cause = CAUSE_BKPT;
    else if (lim)  cause = CAUSE_LIMIT;
  end

endmodule

// File: rtl/sccpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// Module: sccpu_run_ctrl
// Run/halt/single-step sequencer for the single-cycle MIPS core. Produces the
// single commit enable (cpu_en) gating PC update, RF write and MemWrite, and
// stops the core before an instruction that hits a stop condition commits.
// Build option: RUN_CTRL_BKPT_EN enables the PC breakpoint (stop cause 2).
// Ports:
//   clk        in  1      core clock
//   rst        in  1      synchronous, active-low reset
//   run_req    in  1      leave IDLE/HALT and free-run
//   halt_req   in  1      stop before the current instruction commits
//   step_req   in  1      execute exactly one instruction, then HALT
//   clr_cnt    in  1      zero instr_cnt (ignored while cpu_en=1)
//   pc         in  32     current core PC
//   instr      in  32     instruction at pc
//   bkpt_addr  in  32     breakpoint PC
//   bkpt_valid in  1      breakpoint armed
//   cpu_en     out 1      combinational commit enable
//   halted     out 1      registered; 1 in IDLE/HALT
//   state      out 2      FSM state (sccpu_dbg_defs encoding)
//   stop_cause out 2      registered reason for the last HALT entry
//   instr_cnt  out CNT_W  retired instructions, saturating
// ----------------------------------------------------------------------------
module sccpu_run_ctrl
  import sccpu_dbg_defs::*;
#(
  parameter int unsigned       CNT_W     = 32,
  parameter logic [CNT_W-1:0]  MAX_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              clr_cnt,
  input  logic [31:0]       pc,
  input  logic [31:0]       instr,
  input  logic [31:0]       bkpt_addr,
  input  logic              bkpt_valid,
  output logic              cpu_en,
  output logic              halted,
  output logic [1:0]        state,
  output logic [1:0]        stop_cause,
  output logic [CNT_W-1:0]  instr_cnt
);

  run_state_t       state_q, state_d;
  stop_cause_t      cause_q, cause_d;
  stop_cause_t      det_cause;
  logic             skip_q, skip_d;
  logic             halted_q;
  logic             stop;
  logic [CNT_W-1:0] cnt_q;

  run_ctrl_stopdet #(
    .CNT_W     (CNT_W),
    .MAX_INSTR (MAX_INSTR)
  ) u_stopdet (
    .halt_req   (halt_req),
    .skip       (skip_q),
    .instr      (instr),
    .pc         (pc),
    .bkpt_addr  (bkpt_addr),
    .bkpt_valid (bkpt_valid),
    .instr_cnt  (cnt_q),
    .stop       (stop),
    .cause      (det_cause)
  );

  // Next-state and commit enable. cpu_en drops in the same cycle a stop is
  // detected so the offending instruction never commits.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    skip_d  = skip_q;
    cpu_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (halt_req) begin
          state_d = state_q;
        end else if (step_req) begin
          state_d = ST_STEP;
          skip_d  = 1'b0;
        end else if (run_req) begin
          state_d = ST_RUN;
          skip_d  = (state_q == ST_HALT);
        end
      end
      ST_STEP: begin
        cpu_en  = 1'b1;
        state_d = ST_HALT;
        cause_d = CAUSE_HOST;
        skip_d  = 1'b0;
      end
      ST_RUN: begin
        skip_d = 1'b0;
        if (stop) begin
          state_d = ST_HALT;
          cause_d = det_cause;
        end else begin
          cpu_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst) cpu_en = 1'b0;
  end

  // State, flags and the saturating retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cause_q  <= CAUSE_HOST;
      skip_q   <= 1'b0;
      halted_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      skip_q   <= skip_d;
      halted_q <= (state_d == ST_IDLE) || (state_d == ST_HALT);
      if (cpu_en) begin
        if (cnt_q != '1) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (clr_cnt) begin
        cnt_q <= '0;
      end
    end
  end

  assign state      = state_q;
  assign stop_cause = cause_q;
  assign halted     = halted_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_sccpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench: tb_sccpu_run_ctrl
// Directed scenarios for the run controller. u_dut uses the default build
// (no instruction limit); u_lim is a 3-bit-counter instance with MAX_INSTR=5
// used for the limit and saturation scenarios. Breakpoint expectations follow
// RUN_CTRL_BKPT_EN.
// ----------------------------------------------------------------------------
module tb_sccpu_run_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] BRK = 32'h0000_000D;

  logic        clk;
  logic        rst;
  logic        run_req, halt_req, step_req, clr_cnt;
  logic [31:0] pc, instr, bkpt_addr;
  logic        bkpt_valid;

  logic        cpu_en, halted;
  logic [1:0]  state, stop_cause;
  logic [31:0] instr_cnt;

  logic        lim_cpu_en, lim_halted;
  logic [1:0]  lim_state, lim_stop_cause;
  logic [2:0]  lim_instr_cnt;

  int checks   = 0;
  int failures = 0;

  sccpu_run_ctrl u_dut (
    .clk (clk), .rst (rst), .run_req (run_req), .halt_req (halt_req),
    .step_req (step_req), .clr_cnt (clr_cnt), .pc (pc), .instr (instr),
    .bkpt_addr (bkpt_addr), .bkpt_valid (bkpt_valid), .cpu_en (cpu_en),
    .halted (halted), .state (state), .stop_cause (stop_cause),
    .instr_cnt (instr_cnt)
  );

  sccpu_run_ctrl #(.CNT_W (3), .MAX_INSTR (3'd5)) u_lim (
    .clk (clk), .rst (rst), .run_req (run_req), .halt_req (halt_req),
    .step_req (step_req), .clr_cnt (clr_cnt), .pc (pc), .instr (instr),
    .bkpt_addr (bkpt_addr), .bkpt_valid (bkpt_valid), .cpu_en (lim_cpu_en),
    .halted (lim_halted), .state (lim_state), .stop_cause (lim_stop_cause),
    .instr_cnt (lim_instr_cnt)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Advance past the next rising edge; inputs change and registered outputs
  // are sampled here, well away from the edge.
  task automatic next_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    clr_cnt = 1'b0; instr = NOP; pc = 32'h0000_3000;
    next_edge();
    next_edge();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; run_req = 1'b1; halt_req = 1'b0; step_req = 1'b0;
    clr_cnt = 1'b0; instr = NOP; pc = 32'h0000_3000;
    bkpt_addr = 32'h0000_3010; bkpt_valid = 1'b0;
    next_edge();
    next_edge();
    #1;
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_en got=%0b exp=0", cpu_en); end
    checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
    checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL reset_halted got=%0b exp=1", halted); end
    checks++; if (stop_cause !== 2'd0) begin failures++; $display("[TB] FAIL reset_cause got=%0d exp=0", stop_cause); end
    checks++; if (instr_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", instr_cnt); end
    run_req = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_run_nops();
    run_req = 1'b1;
    #1;
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL run_idle_en got=%0b exp=0", cpu_en); end
    next_edge();
    run_req = 1'b0;
    #1;
    checks++; if (state !== 2'd1) begin failures++; $display("[TB] FAIL run_state got=%0d exp=1", state); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL run_halted got=%0b exp=0", halted); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL run_en[%0d] got=%0b exp=1", i, cpu_en); end
      next_edge();
      pc = pc + 32'd4;
    end
    checks++; if (instr_cnt !== 32'd10) begin failures++; $display("[TB] FAIL run_cnt got=%0d exp=10", instr_cnt); end
  endtask

  task automatic test_break_resume();
    instr = BRK;
    #1;
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL brk_en got=%0b exp=0", cpu_en); end
    next_edge();
    checks++; if (state !== 2'd3) begin failures++; $display("[TB] FAIL brk_state got=%0d exp=3", state); end
    checks++; if (stop_cause !== 2'd1) begin failures++; $display("[TB] FAIL brk_cause got=%0d exp=1", stop_cause); end
    checks++; if (instr_cnt !== 32'd10) begin failures++; $display("[TB] FAIL brk_cnt got=%0d exp=10", instr_cnt); end
    run_req = 1'b1;
    next_edge();
    run_req = 1'b0;
    #1;
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL resume_en got=%0b exp=1", cpu_en); end
    next_edge();
    instr = NOP;
    pc = pc + 32'd4;
    #1;
    checks++; if (instr_cnt !== 32'd11) begin failures++; $display("[TB] FAIL resume_cnt got=%0d exp=11", instr_cnt); end
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL resume_cont got=%0b exp=1", cpu_en); end
    next_edge();
  endtask

  task automatic test_step();
    halt_req = 1'b1;
    #1;
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL halt_en got=%0b exp=0", cpu_en); end
    next_edge();
    halt_req = 1'b0;
    checks++; if (stop_cause !== 2'd0) begin failures++; $display("[TB] FAIL halt_cause got=%0d exp=0", stop_cause); end
    checks++; if (instr_cnt !== 32'd12) begin failures++; $display("[TB] FAIL halt_cnt got=%0d exp=12", instr_cnt); end
    instr = BRK;
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      next_edge();
      step_req = 1'b0;
      #1;
      checks++; if (cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL step_en[%0d] got=%0b exp=1", i, cpu_en); end
      next_edge();
      #1;
      checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL step_halted[%0d] got=%0b exp=1", i, halted); end
      checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL step_after_en[%0d] got=%0b exp=0", i, cpu_en); end
    end
    checks++; if (instr_cnt !== 32'd15) begin failures++; $display("[TB] FAIL step_cnt got=%0d exp=15", instr_cnt); end
    instr = NOP;
  endtask

  task automatic test_halt_run_same();
    halt_req = 1'b1;
    run_req  = 1'b1;
    next_edge();
    halt_req = 1'b0;
    run_req  = 1'b0;
    #1;
    checks++; if (state !== 2'd3) begin failures++; $display("[TB] FAIL halt_run_state got=%0d exp=3", state); end
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL halt_run_en got=%0b exp=0", cpu_en); end
  endtask

  task automatic test_clr_cnt();
    clr_cnt = 1'b1;
    next_edge();
    clr_cnt = 1'b0;
    checks++; if (instr_cnt !== 32'd0) begin failures++; $display("[TB] FAIL clr_halt got=%0d exp=0", instr_cnt); end
    run_req = 1'b1;
    next_edge();
    run_req = 1'b0;
    clr_cnt = 1'b1;
    next_edge();
    clr_cnt = 1'b0;
    checks++; if (instr_cnt !== 32'd1) begin failures++; $display("[TB] FAIL clr_run got=%0d exp=1", instr_cnt); end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b0;
    #1;
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL rstrun_en got=%0b exp=0", cpu_en); end
    next_edge();
    checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL rstrun_state got=%0d exp=0", state); end
    checks++; if (instr_cnt !== 32'd0) begin failures++; $display("[TB] FAIL rstrun_cnt got=%0d exp=0", instr_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_limit();
    apply_reset();
    run_req = 1'b1;
    next_edge();
    run_req = 1'b0;
    for (int i = 0; i < 5; i++) next_edge();
    #1;
    checks++; if (lim_instr_cnt !== 3'd5) begin failures++; $display("[TB] FAIL lim_cnt got=%0d exp=5", lim_instr_cnt); end
    checks++; if (lim_cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL lim_en got=%0b exp=0", lim_cpu_en); end
    next_edge();
    checks++; if (lim_state !== 2'd3) begin failures++; $display("[TB] FAIL lim_state got=%0d exp=3", lim_state); end
    checks++; if (lim_stop_cause !== 2'd3) begin failures++; $display("[TB] FAIL lim_cause got=%0d exp=3", lim_stop_cause); end
    step_req = 1'b1;
    next_edge();
    step_req = 1'b0;
    next_edge();
    checks++; if (lim_instr_cnt !== 3'd6) begin failures++; $display("[TB] FAIL lim_step_cnt got=%0d exp=6", lim_instr_cnt); end
    run_req = 1'b1;
    next_edge();
    run_req = 1'b0;
    next_edge();
    next_edge();
    #1;
    checks++; if (lim_instr_cnt !== 3'd7) begin failures++; $display("[TB] FAIL sat_cnt got=%0d exp=7", lim_instr_cnt); end
    checks++; if (lim_cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL sat_en got=%0b exp=1", lim_cpu_en); end
  endtask

  task automatic test_bkpt();
    apply_reset();
    bkpt_addr  = 32'h0000_3010;
    bkpt_valid = 1'b1;
    run_req = 1'b1;
    next_edge();
    run_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_edge();
      pc = pc + 32'd4;
    end
    #1;
`ifdef RUN_CTRL_BKPT_EN
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL bkpt_en got=%0b exp=0", cpu_en); end
    next_edge();
    checks++; if (state !== 2'd3) begin failures++; $display("[TB] FAIL bkpt_state got=%0d exp=3", state); end
    checks++; if (stop_cause !== 2'd2) begin failures++; $display("[TB] FAIL bkpt_cause got=%0d exp=2", stop_cause); end
    checks++; if (instr_cnt !== 32'd4) begin failures++; $display("[TB] FAIL bkpt_cnt got=%0d exp=4", instr_cnt); end
    run_req = 1'b1;
    next_edge();
    run_req = 1'b0;
    #1;
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL bkpt_resume_en got=%0b exp=1", cpu_en); end
`else
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL nobkpt_en got=%0b exp=1", cpu_en); end
    next_edge();
    checks++; if (state !== 2'd1) begin failures++; $display("[TB] FAIL nobkpt_state got=%0d exp=1", state); end
    checks++; if (instr_cnt !== 32'd5) begin failures++; $display("[TB] FAIL nobkpt_cnt got=%0d exp=5", instr_cnt); end
`endif
    bkpt_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_nops();
    test_break_resume();
    test_step();
    test_halt_run_same();
    test_clr_cnt();
    test_reset_mid_run();
    test_limit();
    test_bkpt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
